handshake_monitor_array: RTL and testbench

- Parametrised passive bind-style monitor for N_CH ready/valid channels, each carrying WIDTH-bit data.
- Per cycle and per channel it tracks transfers and stalls, and flags three protocol violations: valid dropped before ready, data unstable while stalled, and stall timeout.
- Sits beside the RTL under test and drives no DUT signal.
- Results are exposed as sticky error flags and per-channel transfer counters for testbench readback.

---
 rtl/handshake_monitor_array.sv | 162 ++++++++++++++++
 tb/tb_handshake_monitor_array.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/handshake_monitor_array.sv
// Passive ready/valid protocol monitor for N_CH channels: transfer counters plus sticky
// drop / unstable / timeout flags. Define HANDSHAKE_MONITOR_ASSERT_EN to add per-channel SVA.
module handshake_monitor_array #(
   parameter int N_CH      = 4,
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 32
) (
   input  logic                                     CLK,
   input  logic                                     ASYNCRESETN,
   input  logic                                     clr,
   input  logic [N_CH-1:0]                          valid,
   input  logic [N_CH-1:0]                          ready,
   input  logic [N_CH*WIDTH-1:0]                    data,
   output logic [N_CH*CNT_W-1:0]                    xfer_count,
   output logic [N_CH-1:0]                          err_drop,
   output logic [N_CH-1:0]                          err_unstable,
   output logic [N_CH-1:0]                          err_timeout,
   output logic                                     err_any,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_err_ch
);

   localparam int FCW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SCW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
   localparam logic [SCW-1:0] STALL_LIM = SCW'(MAX_STALL);

   typedef enum logic [1:0] {IDLE, WAIT, TIMEOUT} state_t;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   function automatic logic [SCW-1:0] sat_inc_stall(input logic [SCW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic [N_CH-1:0] new_err;
   logic [FCW-1:0]  first_idx;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [SCW-1:0]   stall_q, stall_d;
      logic [WIDTH-1:0] cap_q, cap_d, din;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             drop_q, unst_q, tmo_q;
      logic             drop_d, unst_d, tmo_d;

      assign din = data[i*WIDTH +: WIDTH];

      always_comb begin
         state_d = state_q;
         stall_d = stall_q;
         cap_d   = cap_q;
         cnt_d   = cnt_q;
         drop_d  = 1'b0;
         unst_d  = 1'b0;
         tmo_d   = 1'b0;
         if (valid[i] && ready[i]) cnt_d = sat_inc_cnt(cnt_q);
         case (state_q)
            IDLE: begin
               if (valid[i] && !ready[i]) begin
                  cap_d   = din;
                  stall_d = SCW'(1);
                  if (MAX_STALL == 1) begin
                     state_d = TIMEOUT;
                     tmo_d   = 1'b1;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
            WAIT, TIMEOUT: begin
               // captured payload is frozen for the whole stall, including the accepting cycle
               if (valid[i] && din != cap_q) unst_d = 1'b1;
               if (!valid[i]) begin
                  state_d = IDLE;
                  drop_d  = 1'b1;
               end else if (ready[i]) begin
                  state_d = IDLE;
               end else if (state_q == WAIT) begin
                  stall_d = sat_inc_stall(stall_q);
                  if (MAX_STALL != 0 && stall_d == STALL_LIM) begin
                     state_d = TIMEOUT;
                     tmo_d   = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge CLK or negedge ASYNCRESETN) begin
         if (!ASYNCRESETN) begin
            state_q <= IDLE;
            stall_q <= '0;
            cap_q   <= '0;
         end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            cap_q   <= cap_d;
         end
      end

      // clr only touches the readback state; the protocol tracker keeps running
      always_ff @(posedge CLK or negedge ASYNCRESETN) begin
         if (!ASYNCRESETN) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            unst_q <= 1'b0;
            tmo_q  <= 1'b0;
         end else if (clr) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            unst_q <= 1'b0;
            tmo_q  <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_q | drop_d;
            unst_q <= unst_q | unst_d;
            tmo_q  <= tmo_q | tmo_d;
         end
      end

      assign xfer_count[i*CNT_W +: CNT_W] = cnt_q;
      assign err_drop[i]     = drop_q;
      assign err_unstable[i] = unst_q;
      assign err_timeout[i]  = tmo_q;
      assign new_err[i]      = drop_d | unst_d | tmo_d;

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
      a_drop: assert property (@(posedge CLK) disable iff (!ASYNCRESETN) !drop_d)
         else $error("handshake_monitor_array: valid dropped while stalled on channel %0d", i);
      a_unstable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN) !unst_d)
         else $error("handshake_monitor_array: data changed while stalled on channel %0d", i);
      a_timeout: assert property (@(posedge CLK) disable iff (!ASYNCRESETN) !tmo_d)
         else $error("handshake_monitor_array: stall timeout on channel %0d", i);
`else
      // checker-free build: flags and counters above are the only observation path
`endif
   end

   always_comb begin
      first_idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (new_err[k]) first_idx = FCW'(k);
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         err_any      <= 1'b0;
         first_err_ch <= '0;
      end else if (clr) begin
         err_any      <= 1'b0;
         first_err_ch <= '0;
      end else begin
         err_any <= err_any | (|new_err);
         if (!err_any && (|new_err)) first_err_ch <= first_idx;
      end
   end

endmodule

// File: tb/tb_handshake_monitor_array.sv
// Directed bench for handshake_monitor_array: default-parameter instance driven from a
// vector table, plus a MAX_STALL=4 / CNT_W=3 instance for timeout and saturation sequences.
module tb_handshake_monitor_array;

   logic        CLK = 1'b0;
   logic        ASYNCRESETN;
   logic        clr;
   logic [3:0]  valid, ready;
   logic [31:0] data;

   logic [63:0] cnt_a;
   logic [3:0]  drop_a, unst_a, tmo_a;
   logic        any_a;
   logic [1:0]  first_a;
   logic [11:0] cnt_b;
   logic [3:0]  drop_b, unst_b, tmo_b;
   logic        any_b;
   logic [1:0]  first_b;
   logic [14:0] err_a, err_b;

   assign err_a = {drop_a, unst_a, tmo_a, any_a, first_a};
   assign err_b = {drop_b, unst_b, tmo_b, any_b, first_b};

   always #5 CLK = ~CLK;

   handshake_monitor_array #(.N_CH(4), .WIDTH(8), .CNT_W(16), .MAX_STALL(32)) dut_a (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr), .valid(valid), .ready(ready),
      .data(data), .xfer_count(cnt_a), .err_drop(drop_a), .err_unstable(unst_a),
      .err_timeout(tmo_a), .err_any(any_a), .first_err_ch(first_a)
   );

   handshake_monitor_array #(.N_CH(4), .WIDTH(8), .CNT_W(3), .MAX_STALL(4)) dut_b (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr), .valid(valid), .ready(ready),
      .data(data), .xfer_count(cnt_b), .err_drop(drop_b), .err_unstable(unst_b),
      .err_timeout(tmo_b), .err_any(any_b), .first_err_ch(first_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          rep;
      logic        clr;
      logic [3:0]  valid;
      logic [3:0]  ready;
      logic [31:0] data;
      logic [63:0] exp_cnt;
      logic [14:0] exp_err;
   } vec_t;

   localparam int NV = 15;
   vec_t vec [NV];

   initial begin
      // exp_err = {drop[3:0], unstable[3:0], timeout[3:0], err_any, first_err_ch}
      vec[0]  = '{10, 1'b0, 4'b0001, 4'b0001, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd10}, {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[1]  = '{3,  1'b0, 4'b0010, 4'b0000, 32'h0000_A500, {16'd0, 16'd0, 16'd0, 16'd10}, {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[2]  = '{1,  1'b0, 4'b0010, 4'b0010, 32'h0000_A500, {16'd0, 16'd0, 16'd1, 16'd10}, {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[3]  = '{1,  1'b0, 4'b0100, 4'b0000, 32'h003C_0000, {16'd0, 16'd0, 16'd1, 16'd10}, {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[4]  = '{1,  1'b0, 4'b0100, 4'b0000, 32'h003D_0000, {16'd0, 16'd0, 16'd1, 16'd10}, {4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2}};
      vec[5]  = '{1,  1'b1, 4'b0100, 4'b0100, 32'h003D_0000, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[6]  = '{1,  1'b0, 4'b0000, 4'b0000, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[7]  = '{2,  1'b0, 4'b1001, 4'b0000, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0}};
      vec[8]  = '{1,  1'b0, 4'b0000, 4'b0000, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b1001, 4'b0000, 4'b0000, 1'b1, 2'd0}};
      vec[9]  = '{1,  1'b0, 4'b0010, 4'b0000, 32'h0000_1100, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b1001, 4'b0000, 4'b0000, 1'b1, 2'd0}};
      vec[10] = '{1,  1'b0, 4'b0000, 4'b0000, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd0},  {4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0}};
      vec[11] = '{2,  1'b0, 4'b0001, 4'b0001, 32'h0000_0000, {16'd0, 16'd0, 16'd0, 16'd2},  {4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0}};
      vec[12] = '{1,  1'b0, 4'b1000, 4'b0000, 32'h5500_0000, {16'd0, 16'd0, 16'd0, 16'd2},  {4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0}};
      vec[13] = '{1,  1'b0, 4'b1000, 4'b1000, 32'h5600_0000, {16'd1, 16'd0, 16'd0, 16'd2},  {4'b1011, 4'b1000, 4'b0000, 1'b1, 2'd0}};
      vec[14] = '{1,  1'b0, 4'b1111, 4'b1111, 32'h0102_0304, {16'd2, 16'd1, 16'd1, 16'd3},  {4'b1011, 4'b1000, 4'b0000, 1'b1, 2'd0}};

      ASYNCRESETN = 1'b0;
      clr   = 1'b0;
      valid = '0;
      ready = '0;
      data  = '0;
      repeat (2) @(negedge CLK);
      chk("reset_cnt_a", cnt_a, 64'd0);
      chk("reset_err_a", err_a, 64'd0);
      chk("reset_cnt_b", cnt_b, 64'd0);
      chk("reset_err_b", err_b, 64'd0);
      ASYNCRESETN = 1'b1;

      for (int r = 0; r < NV; r++) begin
         clr   = vec[r].clr;
         valid = vec[r].valid;
         ready = vec[r].ready;
         data  = vec[r].data;
         repeat (vec[r].rep) @(negedge CLK);
         chk($sformatf("vec%0d_cnt", r), cnt_a, vec[r].exp_cnt);
         chk($sformatf("vec%0d_err", r), err_a, 64'(vec[r].exp_err));
      end

      // stall timeout on the MAX_STALL=4 instance, then clr racing a transfer
      clr = 1'b1; valid = '0; ready = '0; data = '0;
      @(negedge CLK);
      chk("clr_b_err", err_b, 64'd0);
      clr = 1'b0; valid = 4'b0010;
      repeat (3) @(negedge CLK);
      chk("tmo_before_lim", tmo_b, 64'd0);
      @(negedge CLK);
      chk("tmo_at_lim", tmo_b, 64'b0010);
      chk("tmo_any_b", any_b, 64'd1);
      chk("tmo_first_b", first_b, 64'd1);
      chk("tmo_none_a", tmo_a, 64'd0);
      clr = 1'b1; ready = 4'b0010;
      @(negedge CLK);
      chk("clr_xfer_err_b", err_b, 64'd0);
      chk("clr_xfer_cnt_b", cnt_b, 64'd0);

      // counter saturation on CNT_W=3 while channel 2 sits stalled
      clr = 1'b0; valid = 4'b0101; ready = 4'b0001; data = 32'h0077_0000;
      repeat (7) @(negedge CLK);
      chk("sat_cnt7_b", cnt_b[2:0], 64'd7);
      repeat (2) @(negedge CLK);
      chk("sat_hold_b", cnt_b[2:0], 64'd7);
      chk("nosat_cnt_a", cnt_a[15:0], 64'd9);
      chk("long_stall_err_a", err_a, 64'd0);

      // asynchronous reset mid-cycle, then fresh stall with new data
      #2;
      ASYNCRESETN = 1'b0;
      valid = 4'b0100; ready = 4'b0000; data = 32'h0078_0000;
      #1;
      chk("async_rst_cnt_a", cnt_a, 64'd0);
      chk("async_rst_cnt_b", cnt_b, 64'd0);
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      repeat (2) @(negedge CLK);
      chk("fresh_stall_err_a", err_a, 64'd0);
      valid = 4'b0000;
      @(negedge CLK);
      chk("post_rst_drop_a", err_a, 64'({4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
